// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_RESP = 2'd1,
    RMW_WR  = 2'd2,
    WR_ACK  = 2'd3
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [STRB_W-1:0] WSTRB_FULL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus memory port signals seen by the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_req_addr;
  logic              if_resp_valid;
  logic [31:0]       if_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [31:0]       d_req_addr;
  logic [31:0]       d_req_wdata;
  logic [3:0]        d_req_wstrb;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;

  logic [ADDR_W-1:0] mem_addra;
  logic [31:0]       mem_dina;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addrb;
  logic [31:0]       mem_doutb;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_addra, mem_dina, mem_wea, mem_addrb,
    input  mem_doutb
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_addra, mem_dina, mem_wea, mem_addrb,
    output mem_doutb
  );
endinterface

// File: rtl/mem_byte_merge.sv
// Byte-lane merge for partial stores: strobed lanes from the new word, the rest from the old one.
module mem_byte_merge
  import mem_port_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) merged_c[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one dual-port memory between fetch and data requesters; partial stores run as read-modify-write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam logic RR_MODE = (PRIO_MODE == 0);

  state_t              state, state_nxt;
  logic                rr_last, rr_last_nxt;
  logic                owner, owner_nxt;
  logic                lat_en;
  logic [ADDR_W-1:0]   lat_idx;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;
  logic [ADDR_W-1:0]   if_idx, d_idx;
  logic                grant_if, grant_d;
  logic [DATA_W-1:0]   merged;

  assign if_idx = bus.if_req_addr[ADDR_W+1:2];
  assign d_idx  = bus.d_req_addr[ADDR_W+1:2];

  // Byte offset and upper address bits are deliberately dropped so addresses wrap.
  wire unused_addr_bits = ^{bus.if_req_addr[31:ADDR_W+2], bus.if_req_addr[1:0],
                            bus.d_req_addr[31:ADDR_W+2], bus.d_req_addr[1:0]};

  assign grant_if = (state == IDLE) && bus.if_req_valid &&
                    (!bus.d_req_valid || (RR_MODE && (rr_last == REQ_D)));
  assign grant_d  = (state == IDLE) && bus.d_req_valid && !grant_if;

  mem_byte_merge u_merge (
    .old_word (bus.mem_doutb),
    .new_word (lat_wdata),
    .strb     (lat_wstrb),
    .merged_c (merged)
  );

  // State, arbitration history and response owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= REQ_D;
      owner   <= REQ_IF;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
      owner   <= owner_nxt;
    end
  end

  // Partial-store context held across the read half of the RMW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (lat_en) begin
      lat_idx   <= d_idx;
      lat_wdata <= bus.d_req_wdata;
      lat_wstrb <= bus.d_req_wstrb;
    end
  end

  always_comb begin
    state_nxt         = state;
    rr_last_nxt       = rr_last;
    owner_nxt         = owner;
    lat_en            = 1'b0;
    bus.if_req_ready  = 1'b0;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_data  = '0;
    bus.d_req_ready   = 1'b0;
    bus.d_resp_valid  = 1'b0;
    bus.d_resp_data   = '0;
    bus.mem_addra     = '0;
    bus.mem_dina      = '0;
    bus.mem_wea       = 1'b0;
    bus.mem_addrb     = '0;

    unique case (state)
      IDLE: begin
        if (grant_if) begin
          bus.if_req_ready = 1'b1;
          bus.mem_addrb    = if_idx;
          rr_last_nxt      = REQ_IF;
          owner_nxt        = REQ_IF;
          state_nxt        = RD_RESP;
        end else if (grant_d) begin
          bus.d_req_ready = 1'b1;
          rr_last_nxt     = REQ_D;
          owner_nxt       = REQ_D;
          if (!bus.d_req_we) begin
            bus.mem_addrb = d_idx;
            state_nxt     = RD_RESP;
          end else if (bus.d_req_wstrb == WSTRB_FULL) begin
            bus.mem_wea   = 1'b1;
            bus.mem_addra = d_idx;
            bus.mem_dina  = bus.d_req_wdata;
            state_nxt     = WR_ACK;
          end else if (bus.d_req_wstrb == '0) begin
            state_nxt     = WR_ACK;
          end else begin
            bus.mem_addrb = d_idx;
            lat_en        = 1'b1;
            state_nxt     = RMW_WR;
          end
        end
      end
      RD_RESP: begin
        if (owner == REQ_IF) begin
          bus.if_resp_valid = 1'b1;
          bus.if_resp_data  = bus.mem_doutb;
        end else begin
          bus.d_resp_valid  = 1'b1;
          bus.d_resp_data   = bus.mem_doutb;
        end
        state_nxt = IDLE;
      end
      RMW_WR: begin
        bus.mem_wea      = 1'b1;
        bus.mem_addra    = lat_idx;
        bus.mem_dina     = merged;
        bus.d_resp_valid = 1'b1;
        state_nxt        = IDLE;
      end
      WR_ACK: begin
        bus.d_resp_valid = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized cycle-level reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wea_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(15)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(15)) b1 ();

  mem_port_arbiter #(.ADDR_W(15), .PRIO_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  mem_port_arbiter #(.ADDR_W(15), .PRIO_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  // Behavioural memories: registered, write-first read port.
  logic [31:0] mem0 [0:32767];
  logic [31:0] mem1 [0:32767];

  always @(posedge clk) begin
    if (b0.mem_wea) mem0[b0.mem_addra] <= b0.mem_dina;
    b0.mem_doutb <= (b0.mem_wea && b0.mem_addra == b0.mem_addrb) ? b0.mem_dina : mem0[b0.mem_addrb];
    if (b1.mem_wea) mem1[b1.mem_addra] <= b1.mem_dina;
    b1.mem_doutb <= (b1.mem_wea && b1.mem_addra == b1.mem_addrb) ? b1.mem_dina : mem1[b1.mem_addrb];
  end

  always @(negedge clk) if (b0.mem_wea === 1'b1) wea_cnt <= wea_cnt + 1;

  // Reference memory image, indexed by word number.
  logic [31:0] ref_mem [int];

  function automatic int ref_idx(input logic [31:0] addr);
    return int'((addr >> 2) % 32768);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    return ref_mem.exists(ref_idx(addr)) ? ref_mem[ref_idx(addr)] : 32'h0;
  endfunction

  function automatic void ref_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] w;
    logic [31:0] m;
    w = ref_read(addr);
    for (int b = 0; b < 4; b++) begin
      m = 32'hFF << (8 * b);
      if (strb[b]) w = (w & ~m) | (wd & m);
    end
    ref_mem[ref_idx(addr)] = w;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One data transaction on b0; lat = cycles from handshake to response, -1 on timeout.
  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk); #1;
    b0.d_req_valid = 1'b1; b0.d_req_we = we; b0.d_req_addr = addr;
    b0.d_req_wdata = wd;   b0.d_req_wstrb = st;
    rd = 32'hx; lat = -1; n = 0;
    forever begin
      @(negedge clk);
      if (b0.d_req_ready) break;
      n++;
      if (n > 50) break;
    end
    @(posedge clk); #1;
    b0.d_req_valid = 1'b0;
    if (n > 50) return;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b0.d_resp_valid) begin rd = b0.d_resp_data; lat = c; break; end
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    int n;
    @(posedge clk); #1;
    b0.if_req_valid = 1'b1; b0.if_req_addr = addr;
    rd = 32'hx; lat = -1; n = 0;
    forever begin
      @(negedge clk);
      if (b0.if_req_ready) break;
      n++;
      if (n > 50) break;
    end
    @(posedge clk); #1;
    b0.if_req_valid = 1'b0;
    if (n > 50) return;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b0.if_resp_valid) begin rd = b0.if_resp_data; lat = c; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    @(negedge clk);
    outs = {b0.if_req_ready, b0.d_req_ready, b0.if_resp_valid, b0.d_resp_valid, b0.mem_wea, 27'h0};
    n_checks++;
    if (outs !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", outs); end
    n_checks++;
    if ({b0.if_resp_data, b0.d_resp_data} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h/%h want 0", b0.if_resp_data, b0.d_resp_data);
    end
    n_checks++;
    if ({b0.mem_addra, b0.mem_addrb, b0.mem_dina} !== 62'h0) begin
      n_fail++; $display("FAIL reset_memport got %h %h %h want 0", b0.mem_addra, b0.mem_addrb, b0.mem_dina);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int lat;
    do_data(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, lat);
    do_fetch(32'h40, rd, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL fetch_latency got %0d want 1", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_data got %h want deadbeef", rd); end
  endtask

  task automatic test_full_store();
    logic [31:0] rd; int lat; int w0;
    @(posedge clk);
    w0 = wea_cnt;
    do_data(1'b1, 32'h80, 32'h12345678, 4'hF, rd, lat);
    @(posedge clk);
    n_checks++;
    if (wea_cnt - w0 !== 1) begin n_fail++; $display("FAIL full_store_wea got %0d want 1", wea_cnt - w0); end
    n_checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL full_store_resp got %h lat %0d want 0 lat 1", rd, lat);
    end
    do_data(1'b0, 32'h80, 32'h0, 4'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL full_store_load got %h want 12345678", rd); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; int lat; int w0;
    do_data(1'b1, 32'h80, 32'hAABBCCDD, 4'hF, rd, lat);
    @(posedge clk);
    w0 = wea_cnt;
    do_data(1'b1, 32'h80, 32'h00001100, 4'b0010, rd, lat);
    @(posedge clk);
    n_checks++;
    if (wea_cnt - w0 !== 1 || lat !== 1) begin
      n_fail++; $display("FAIL partial_wea got %0d lat %0d want 1 lat 1", wea_cnt - w0, lat);
    end
    do_data(1'b0, 32'h80, 32'h0, 4'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hAABB11DD) begin n_fail++; $display("FAIL partial_merge got %h want aabb11dd", rd); end
  endtask

  task automatic test_zero_strobe_and_wrap();
    logic [31:0] rd; int lat; int w0;
    @(posedge clk);
    w0 = wea_cnt;
    do_data(1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, rd, lat);
    @(posedge clk);
    n_checks++;
    if (lat !== 1 || wea_cnt - w0 !== 0) begin
      n_fail++; $display("FAIL zero_strb got lat %0d wea %0d want lat 1 wea 0", lat, wea_cnt - w0);
    end
    do_data(1'b0, 32'h80, 32'h0, 4'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hAABB11DD) begin n_fail++; $display("FAIL zero_strb_mem got %h want aabb11dd", rd); end
    do_data(1'b1, 32'h4, 32'h5A5A0001, 4'hF, rd, lat);
    do_data(1'b0, 32'h0002_0004, 32'h0, 4'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h5A5A0001) begin n_fail++; $display("FAIL addr_wrap got %h want 5a5a0001", rd); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0; int n;
    logic [31:0] rd; int lat;
    do_data(1'b1, 32'h300, 32'h11223344, 4'hF, rd, lat);
    @(posedge clk); #1;
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b1; b0.d_req_addr = 32'h300;
    b0.d_req_wdata = 32'hFFFFFFFF; b0.d_req_wstrb = 4'b0101;
    n = 0;
    forever begin
      @(negedge clk);
      if (b0.d_req_ready || n > 50) break;
      n++;
    end
    @(posedge clk);
    w0 = wea_cnt;
    #1 rst_n = 1'b0;
    b0.d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b0.mem_wea, b0.if_req_ready, b0.d_req_ready, b0.if_resp_valid, b0.d_resp_valid} !== 5'b0 ||
        {b0.mem_addra, b0.mem_addrb, b0.mem_dina, b0.d_resp_data} !== 94'h0) begin
      n_fail++; $display("FAIL mid_rmw_outputs got wea %b d_resp %b dina %h want all 0",
                         b0.mem_wea, b0.d_resp_valid, b0.mem_dina);
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (wea_cnt !== w0) begin n_fail++; $display("FAIL mid_rmw_wea got %0d writes want 0", wea_cnt - w0); end
    #1 rst_n = 1'b1;
    b0.if_req_valid = 1'b1; b0.if_req_addr = 32'h300;
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_req_addr = 32'h300;
    @(negedge clk);
    n_checks++;
    if ({b0.if_req_ready, b0.d_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_tie got if/d ready %b%b want 10", b0.if_req_ready, b0.d_req_ready);
    end
    @(posedge clk); #1 b0.if_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.if_resp_valid !== 1'b1 || b0.if_resp_data !== 32'h11223344) begin
      n_fail++; $display("FAIL mid_rmw_unchanged got v%b %h want v1 11223344", b0.if_resp_valid, b0.if_resp_data);
    end
    @(negedge clk);
    n_checks++;
    if (b0.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_d_grant got %b want 1", b0.d_req_ready); end
    @(posedge clk); #1 b0.d_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arb_rr();
    logic rr_m; logic busy; logic [1:0] exp; int n_if, n_d;
    apply_reset();
    b0.if_req_valid = 1'b1; b0.if_req_addr = 32'h40;
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_req_addr = 32'h80;
    rr_m = 1'b1; busy = 1'b0; n_if = 0; n_d = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp = busy ? 2'b00 : (rr_m ? 2'b10 : 2'b01);
      n_checks++;
      if ({b0.if_req_ready, b0.d_req_ready} !== exp) begin
        n_fail++; $display("FAIL rr_grant cyc %0d got %b%b want %b", c, b0.if_req_ready, b0.d_req_ready, exp);
      end
      if (exp == 2'b10) begin rr_m = 1'b0; n_if++; end
      if (exp == 2'b01) begin rr_m = 1'b1; n_d++; end
      busy = (exp != 2'b00);
    end
    n_checks++;
    if (n_if != 6 || n_d != 6) begin n_fail++; $display("FAIL rr_fairness got %0d/%0d want 6/6", n_if, n_d); end
    @(posedge clk); #1;
    b0.if_req_valid = 1'b0; b0.d_req_valid = 1'b0;
    apply_reset();
  endtask

  task automatic test_arb_prio();
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h40;
    b1.d_req_valid = 1'b1; b1.d_req_we = 1'b0; b1.d_req_addr = 32'h80;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_checks++;
      if ({b1.if_req_ready, b1.d_req_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL prio_grant cyc %0d got %b%b want %s", c, b1.if_req_ready, b1.d_req_ready,
                           (c % 2 == 0) ? "01" : "00");
      end
    end
    @(posedge clk); #1;
    b1.if_req_valid = 1'b0; b1.d_req_valid = 1'b0;
    apply_reset();
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'((32'h100 + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3) + ($urandom_range(0, 3) << 17));
  endfunction

  // Random traffic on both requesters against the reference model.
  task automatic test_random();
    logic [31:0] rd; int lat;
    logic if_pend, d_pend, rr_m;
    int grant;
    logic [31:0] exp_data;
    logic [1:0] exp_rdy;
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      ref_store(32'(32'h400 + i * 4), rd, 4'hF);
      do_data(1'b1, 32'(32'h400 + i * 4), rd, 4'hF, rd, lat);
    end
    rr_m = 1'b1; if_pend = 1'b0; d_pend = 1'b0; grant = 0; exp_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (grant == 1) begin if_pend = 1'b0; b0.if_req_valid = 1'b0; end
      if (grant == 2) begin d_pend = 1'b0; b0.d_req_valid = 1'b0; end
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1'b1; b0.if_req_valid = 1'b1; b0.if_req_addr = rnd_addr();
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; b0.d_req_valid = 1'b1; b0.d_req_addr = rnd_addr();
        b0.d_req_we = 1'($urandom_range(0, 1)); b0.d_req_wdata = $urandom; b0.d_req_wstrb = 4'($urandom);
      end
      @(negedge clk);
      n_checks++;
      if (b0.if_resp_valid !== (grant == 1) || b0.if_resp_data !== ((grant == 1) ? exp_data : 32'h0)) begin
        n_fail++; $display("FAIL rnd_if_resp cyc %0d got v%b %h want v%0d %h", c, b0.if_resp_valid,
                           b0.if_resp_data, grant == 1, (grant == 1) ? exp_data : 32'h0);
      end
      n_checks++;
      if (b0.d_resp_valid !== (grant == 2) || b0.d_resp_data !== ((grant == 2) ? exp_data : 32'h0)) begin
        n_fail++; $display("FAIL rnd_d_resp cyc %0d got v%b %h want v%0d %h", c, b0.d_resp_valid,
                           b0.d_resp_data, grant == 2, (grant == 2) ? exp_data : 32'h0);
      end
      if (grant != 0) grant = 0;
      else if (if_pend && (!d_pend || rr_m)) grant = 1;
      else if (d_pend) grant = 2;
      exp_rdy = {grant == 1, grant == 2};
      n_checks++;
      if ({b0.if_req_ready, b0.d_req_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b%b want %b", c, b0.if_req_ready, b0.d_req_ready, exp_rdy);
      end
      if (grant == 1) begin rr_m = 1'b0; exp_data = ref_read(b0.if_req_addr); end
      if (grant == 2) begin
        rr_m = 1'b1;
        if (b0.d_req_we) begin ref_store(b0.d_req_addr, b0.d_req_wdata, b0.d_req_wstrb); exp_data = 32'h0; end
        else exp_data = ref_read(b0.d_req_addr);
      end
    end
    @(posedge clk); #1;
    b0.if_req_valid = 1'b0; b0.d_req_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    b0.if_req_valid = 1'b0; b0.if_req_addr = '0;
    b0.d_req_valid = 1'b0; b0.d_req_we = 1'b0; b0.d_req_addr = '0; b0.d_req_wdata = '0; b0.d_req_wstrb = '0;
    b1.if_req_valid = 1'b0; b1.if_req_addr = '0;
    b1.d_req_valid = 1'b0; b1.d_req_we = 1'b0; b1.d_req_addr = '0; b1.d_req_wdata = '0; b1.d_req_wstrb = '0;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_fetch();
    test_full_store();
    test_partial_store();
    test_zero_strobe_and_wrap();
    test_reset_mid_rmw();
    test_arb_rr();
    test_arb_prio();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-clock controller that shares the 32K-word dual-port memory between two requesters: instruction fetch (read-only) and data access (read/write with byte strobes).
- Drives memory write port A and read port B, whose one-cycle registered read latency is write-first on address collision.
- Serialises requests with a small FSM and implements partial-word stores as read-modify-write.
- Sits between the core's fetch/LSU interfaces and the memory. Both memory clocks are tied to clk at SoC level.

Parameters:
- ADDR_W, 15, memory word-address width (2^ADDR_W words).
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = data requester has fixed priority.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  32  fetch byte address.
- if_resp_valid  out  1  fetch read data valid (1-cycle pulse).
- if_resp_data  out  32  fetch read data.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  32  data byte address.
- d_req_wdata  in  32  store data, lane-aligned.
- d_req_wstrb  in  4  store byte enables.
- d_resp_valid  out  1  load data valid / store complete (1-cycle pulse).
- d_resp_data  out  32  load data; 0 for stores.
- mem_addra  out  ADDR_W  memory write address.
- mem_dina  out  32  memory write data.
- mem_wea  out  1  memory write enable.
- mem_addrb  out  ADDR_W  memory read address.
- mem_doutb  in  32  memory read data, registered by the memory.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - state = IDLE; rr_last = DATA, so fetch wins the first tie.
  - All ready and resp_valid outputs are 0; mem_wea = 0.
  - Response data outputs are 0; mem_addra, mem_addrb and mem_dina are 0.
  - Reset mid-operation aborts any RMW. No write is issued after reset asserts; a half-done RMW leaves memory unchanged.
- Word index is addr[ADDR_W+1:2]. addr[1:0] and the upper bits are ignored, so out-of-range addresses wrap.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready.
  - Requesters hold addr, we, wdata and wstrb stable while valid && !ready.
  - ready is asserted only in IDLE, only for the granted requester, and may depend combinationally on valid.
  - Responses have no backpressure.
- Arbitration (IDLE only):
  - With one requester valid, it is granted.
  - With both valid: PRIO_MODE = 0 grants the one not in rr_last; PRIO_MODE = 1 always grants data.
  - rr_last updates on every grant.
- FSM states: IDLE, RD_RESP, RMW_WR, WR_ACK.
- Load or fetch:
  - In IDLE at grant, mem_addrb = word index combinationally.
  - Next state RD_RESP: the winner's resp_valid = 1 and resp_data = mem_doutb; then IDLE.
  - Latency is 1 cycle after handshake; throughput is 1 access per 2 cycles.
- Full store (wstrb = 4'b1111):
  - In IDLE at grant: mem_wea = 1, mem_addra = index, mem_dina = wdata.
  - Next state WR_ACK: d_resp_valid = 1; then IDLE.
- Partial store (wstrb not 0 and not 1111):
  - In IDLE at grant, mem_addrb = index, and index, wdata and wstrb are latched.
  - Next state RMW_WR: merged lane i = wstrb[i] ? wdata lane i : mem_doutb lane i.
  - In RMW_WR: mem_wea = 1, mem_addra = latched index, mem_dina = merged word, d_resp_valid = 1; then IDLE.
  - 2-cycle occupancy; no other request is granted in between.
- Store with wstrb = 0: no memory write; WR_ACK still pulses.
- Outside IDLE both ready outputs are 0. Pending requests wait and are arbitrated when the FSM returns to IDLE.
- mem_wea is never asserted except in the two write cycles above. Port A and port B never target the same word in the same cycle from separate requests.
- Response data is gated: each resp_data is 0 whenever its resp_valid is 0.

Decomposition:
- Shared package: state encoding localparams (IDLE, RD_RESP, RMW_WR, WR_ACK), requester-ID constants (REQ_IF, REQ_D), WSTRB_FULL = 4'b1111.
- One sub-module, mem_byte_merge: combinational lane merge of old word, new word and wstrb. All other logic is flat.

Test Plan:
- Reset, then preload word 0x10 = 0xDEADBEEF. Fetch addr 0x40 -> if_resp_valid is high exactly 1 cycle after handshake, with if_resp_data = 0xDEADBEEF.
- Data full store addr 0x80, wdata 0x12345678, wstrb 1111, then load 0x80 -> mem_wea for 1 cycle; load returns 0x12345678.
- Word 0x20 = 0xAABBCCDD; store addr 0x80, wdata 0x00001100, wstrb 0010 -> 2 cycles busy; subsequent load returns 0xAABB11DD.
- Both requesters valid continuously with PRIO_MODE = 0 -> grants alternate IF, D, IF, D…; neither starves. With PRIO_MODE = 1 -> D granted every IDLE.
- Assert rst_n low during RMW_WR-pending (cycle after a partial-store handshake) -> no mem_wea pulse; target word unchanged; outputs all 0; fetch wins the first post-reset tie.
- Address wrap: load addr 0x0002_0004 equals word index 1. Store with wstrb 0000 -> d_resp_valid pulses; memory unchanged.
